v68k_alu: RTL and testbench

- Parameterised two-operand integer ALU for the v68k datapath, with 68000-style condition flags C, Z, V, N.
- Operands are computed combinationally, and the result and flags are registered, so they are valid one clock after issue.
- Sits between the register-file read ports and the writeback/CCR logic.

---
 rtl/v68k_alu_if.sv | 29 ++
 rtl/v68k_alu.sv | 134 +++++++++++++
 tb/tb_v68k_alu.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/v68k_alu_if.sv
// v68k_alu_if -- issue/result bundle between the v68k datapath and its ALU.
//   bits : operand/result width
//   en   : issue strobe           a, b : operands (A = destination, B = source)
//   op   : operation select       x    : extend bit (ADDX/SUBX only)
//   o    : registered result      c/z/v/n : registered 68000-style flags
//   xf   : registered extend flag (present only when ALU_XFLAG_EN is defined)
// master = issuing side (datapath / testbench), slave = the ALU.
`timescale 1ns/1ps
interface v68k_alu_if #(parameter int bits = 16);
   logic            en;
   logic [bits-1:0] a;
   logic [bits-1:0] b;
   logic [2:0]      op;
   logic            x;
   logic [bits-1:0] o;
   logic            c;
   logic            z;
   logic            v;
   logic            n;
`ifdef ALU_XFLAG_EN
   logic            xf;

   modport master (output en, a, b, op, x, input o, c, z, v, n, xf);
   modport slave  (input en, a, b, op, x, output o, c, z, v, n, xf);
`else
   modport master (output en, a, b, op, x, input o, c, z, v, n);
   modport slave  (input en, a, b, op, x, output o, c, z, v, n);
`endif
endinterface

// File: rtl/v68k_alu.sv
// v68k_alu -- two-operand integer ALU with 68000-style C/Z/V/N flags.
// Operands are evaluated combinationally; result and flags are registered
// on a rising clk edge with bus.en=1 (fixed one-cycle latency, no stalls).
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (o=0, c=0, z=1, v=0, n=0)
//   bus   : v68k_alu_if.slave (en, a, b, op, x in; o, c, z, v, n [, xf] out)
// Optional build macro ALU_XFLAG_EN: adds the registered extend flag xf,
// which follows c for the arithmetic ops (ADD/ADDX/SUB/SUBX/NEG) and holds
// across the logic ops.
`timescale 1ns/1ps
module v68k_alu #(
   parameter int bits = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   v68k_alu_if.slave  bus
);

   typedef enum logic [2:0] {
      OP_ADD  = 3'd0,
      OP_ADDX = 3'd1,
      OP_SUB  = 3'd2,
      OP_SUBX = 3'd3,
      OP_AND  = 3'd4,
      OP_OR   = 3'd5,
      OP_EOR  = 3'd6,
      OP_NEG  = 3'd7
   } op_e;

   localparam int MSB = bits - 1;
   localparam logic [bits-1:0] MOST_NEG = {1'b1, {(bits-1){1'b0}}};

   op_e             op_s;
   logic            xin_s;
   logic [bits:0]   sum_s;
   logic [bits:0]   dif_s;
   logic [bits-1:0] neg_s;

   logic [bits-1:0] o_q, o_d;
   logic            c_q, c_d;
   logic            z_q, z_d;
   logic            v_q, v_d;
   logic            n_q;

   assign op_s = op_e'(bus.op);

   always_comb begin
      xin_s = 1'b0;
      if (op_s == OP_ADDX || op_s == OP_SUBX) begin
         xin_s = bus.x;
      end
      // One extra bit on top: it is the carry for the sum and the borrow
      // for the difference (the difference goes negative exactly when b+x > a).
      sum_s = {1'b0, bus.a} + {1'b0, bus.b} + {{bits{1'b0}}, xin_s};
      dif_s = {1'b0, bus.a} - {1'b0, bus.b} - {{bits{1'b0}}, xin_s};
      neg_s = {bits{1'b0}} - bus.a;
   end

   always_comb begin
      o_d = {bits{1'b0}};
      c_d = 1'b0;
      v_d = 1'b0;
      case (op_s)
         OP_ADD, OP_ADDX: begin
            o_d = sum_s[bits-1:0];
            c_d = sum_s[bits];
            v_d = (bus.a[MSB] == bus.b[MSB]) && (sum_s[MSB] != bus.a[MSB]);
         end
         OP_SUB, OP_SUBX: begin
            o_d = dif_s[bits-1:0];
            c_d = dif_s[bits];
            v_d = (bus.a[MSB] != bus.b[MSB]) && (dif_s[MSB] != bus.a[MSB]);
         end
         OP_AND: o_d = bus.a & bus.b;
         OP_OR:  o_d = bus.a | bus.b;
         OP_EOR: o_d = bus.a ^ bus.b;
         OP_NEG: begin
            o_d = neg_s;
            c_d = (bus.a != {bits{1'b0}});
            v_d = (bus.a == MOST_NEG);
         end
         default: begin
            o_d = {bits{1'b0}};
         end
      endcase
      // Extended ops can only clear Z so a multi-word chain reports zero
      // only if every word was zero.
      if (op_s == OP_ADDX || op_s == OP_SUBX) begin
         z_d = z_q && (o_d == {bits{1'b0}});
      end else begin
         z_d = (o_d == {bits{1'b0}});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q <= {bits{1'b0}};
         c_q <= 1'b0;
         z_q <= 1'b1;
         v_q <= 1'b0;
         n_q <= 1'b0;
      end else if (bus.en) begin
         o_q <= o_d;
         c_q <= c_d;
         z_q <= z_d;
         v_q <= v_d;
         n_q <= o_d[MSB];
      end
   end

   assign bus.o = o_q;
   assign bus.c = c_q;
   assign bus.z = z_q;
   assign bus.v = v_q;
   assign bus.n = n_q;

`ifdef ALU_XFLAG_EN
   logic xf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xf_q <= 1'b0;
      end else if (bus.en) begin
         if (op_s != OP_AND && op_s != OP_OR && op_s != OP_EOR) begin
            xf_q <= c_d;
         end
      end
   end

   assign bus.xf = xf_q;
`endif

endmodule

// File: tb/tb_v68k_alu.sv
`timescale 1ns/1ps
module tb_v68k_alu;

   localparam int BITS = 16;
   localparam longint MOD  = longint'(1) << BITS;
   localparam longint MASK = MOD - 1;
   localparam longint HALF = longint'(1) << (BITS - 1);

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   v68k_alu_if #(.bits(BITS)) bus();

   v68k_alu #(.bits(BITS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: expected outputs plus the Z and X history.
   logic [BITS-1:0] exp_o;
   logic            exp_c, exp_z, exp_v, exp_n, exp_xf;

   function automatic longint to_signed(input longint u);
      return (u >= HALF) ? u - MOD : u;
   endfunction

   function automatic logic out_of_range(input longint s);
      return (s > HALF - 1) || (s < -HALF);
   endfunction

   task automatic model_reset();
      exp_o = '0; exp_c = 1'b0; exp_z = 1'b1; exp_v = 1'b0; exp_n = 1'b0;
      exp_xf = 1'b0;
   endtask

   task automatic model_issue(input logic [2:0] op, input logic [BITS-1:0] a,
                              input logic [BITS-1:0] b, input logic x);
      longint ua, ub, sa, sb, xi, r;
      logic c, v, ext;
      ua = longint'(a); ub = longint'(b);
      sa = to_signed(ua); sb = to_signed(ub);
      ext = (op == 3'd1) || (op == 3'd3);
      xi = ext ? longint'(x) : 0;
      c = 1'b0; v = 1'b0; r = 0;
      case (op)
         3'd0, 3'd1: begin
            r = ua + ub + xi;
            c = (r > MASK);
            v = out_of_range(sa + sb + xi);
         end
         3'd2, 3'd3: begin
            r = ua - ub - xi;
            c = (ub + xi > ua);
            v = out_of_range(sa - sb - xi);
         end
         3'd4: r = longint'(a & b);
         3'd5: r = longint'(a | b);
         3'd6: r = longint'(a ^ b);
         default: begin
            r = -ua;
            c = (ua != 0);
            v = out_of_range(-sa);
         end
      endcase
      r = r & MASK;
      exp_o = r[BITS-1:0];
      exp_c = c;
      exp_v = v;
      exp_n = exp_o[BITS-1];
      exp_z = ext ? (exp_z && (r == 0)) : (r == 0);
      if (op < 3'd4 || op == 3'd7) exp_xf = c;
   endtask

   task automatic issue(input logic [2:0] op, input logic [BITS-1:0] a,
                        input logic [BITS-1:0] b, input logic x);
      @(negedge clk);
      bus.en = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.x = x;
      model_issue(op, a, b, x);
      @(posedge clk);
      #1;
      bus.en = 1'b0;
   endtask

   function automatic logic [BITS-1:0] pick();
      case ($urandom_range(0, 6))
         0: return '0;
         1: return MASK[BITS-1:0];
         2: return HALF[BITS-1:0];
         3: return (HALF - 1);
         4: return BITS'(1);
         default: return BITS'($urandom);
      endcase
   endfunction

   task automatic test_reset();
      logic [BITS+3:0] got;
      rst_n = 1'b0;
      bus.en = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.x = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      got = {bus.o, bus.c, bus.z, bus.v, bus.n};
      tests++;
      if (got !== {16'h0000, 4'b0100}) begin
         fails++;
         $display("FAIL reset_state: got o=%h czvn=%b want o=0000 czvn=0100",
                  got[BITS+3:4], got[3:0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(3'd0, 16'h0000, 16'h0000, 1'b0);
      got = {bus.o, bus.c, bus.z, bus.v, bus.n};
      tests++;
      if (got !== {16'h0000, 4'b0100}) begin
         fails++;
         $display("FAIL reset_first_add: got o=%h czvn=%b want o=0000 czvn=0100",
                  got[BITS+3:4], got[3:0]);
      end
   endtask

   // Directed arithmetic/logic vectors with hand-derived expectations.
   task automatic test_directed();
      logic [2:0]  t_op [12];
      logic [15:0] t_a  [12];
      logic [15:0] t_b  [12];
      logic        t_x  [12];
      logic [19:0] t_e  [12];
      logic [BITS+3:0] got;
      t_op = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd7,
               3'd4, 3'd5, 3'd6, 3'd0};
      t_a  = '{16'h010F, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000,
               16'h8000, 16'h8000, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h010F};
      t_b  = '{16'h010F, 16'h0001, 16'h0001, 16'hFFFF, 16'h1000, 16'h0001,
               16'h0001, 16'h1234, 16'h0FF0, 16'h0FF0, 16'h0FF0, 16'h010F};
      // x=1 on ops that must ignore it
      t_x  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
               1'b1, 1'b1};
      t_e  = '{{16'h021E, 4'b0000}, {16'h8000, 4'b0011}, {16'h0000, 4'b1100},
               {16'hFFFE, 4'b1001}, {16'h0FFF, 4'b1000}, {16'hFFFF, 4'b1001},
               {16'h7FFF, 4'b0010}, {16'h8000, 4'b1011}, {16'h00F0, 4'b0000},
               {16'hFFF0, 4'b0001}, {16'hFF00, 4'b0001}, {16'h021E, 4'b0000}};
      for (int i = 0; i < 12; i++) begin
         issue(t_op[i], t_a[i], t_b[i], t_x[i]);
         got = {bus.o, bus.c, bus.z, bus.v, bus.n};
         tests++;
         if (got !== t_e[i]) begin
            fails++;
            $display("FAIL directed[%0d] op=%0d a=%h b=%h: got o=%h czvn=%b want o=%h czvn=%b",
                     i, t_op[i], t_a[i], t_b[i], got[BITS+3:4], got[3:0],
                     t_e[i][19:4], t_e[i][3:0]);
         end
      end
   endtask

   task automatic test_extended();
      logic [2:0]  t_op [6];
      logic [15:0] t_a  [6];
      logic [15:0] t_b  [6];
      logic        t_x  [6];
      logic [19:0] t_e  [6];
      logic [BITS+3:0] got;
      // SUB sets z=0, SUBX result 0 must keep z=0; ADDX 1+1+1; then a
      // chain that stays zero and one where SUBX borrows through x.
      t_op = '{3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd3};
      t_a  = '{16'h0000, 16'h0001, 16'h0001, 16'h0005, 16'h0000, 16'h0000};
      t_b  = '{16'h0001, 16'h0000, 16'h0001, 16'h0005, 16'h0000, 16'h0000};
      t_x  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      t_e  = '{{16'hFFFF, 4'b1001}, {16'h0000, 4'b0000}, {16'h0003, 4'b0000},
               {16'h0000, 4'b0100}, {16'h0000, 4'b0100}, {16'hFFFF, 4'b1001}};
      for (int i = 0; i < 6; i++) begin
         issue(t_op[i], t_a[i], t_b[i], t_x[i]);
         got = {bus.o, bus.c, bus.z, bus.v, bus.n};
         tests++;
         if (got !== t_e[i]) begin
            fails++;
            $display("FAIL extended[%0d] op=%0d: got o=%h czvn=%b want o=%h czvn=%b",
                     i, t_op[i], got[BITS+3:4], got[3:0], t_e[i][19:4], t_e[i][3:0]);
         end
      end
   endtask

   task automatic test_hold();
      logic [BITS+3:0] got;
      issue(3'd0, 16'hFFFF, 16'hFFFF, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.en = 1'b0;
         bus.a = BITS'($urandom); bus.b = BITS'($urandom);
         bus.op = 3'($urandom); bus.x = 1'($urandom);
         @(posedge clk);
         #1;
         got = {bus.o, bus.c, bus.z, bus.v, bus.n};
         tests++;
         if (got !== {exp_o, exp_c, exp_z, exp_v, exp_n}) begin
            fails++;
            $display("FAIL hold[%0d]: got o=%h czvn=%b want o=%h czvn=%b",
                     i, got[BITS+3:4], got[3:0], exp_o,
                     {exp_c, exp_z, exp_v, exp_n});
         end
      end
   endtask

   task automatic test_random();
      logic [BITS+3:0] got;
      logic [2:0] op;
      for (int i = 0; i < 400; i++) begin
         op = 3'($urandom);
         issue(op, pick(), pick(), 1'($urandom));
         got = {bus.o, bus.c, bus.z, bus.v, bus.n};
         tests++;
         if (got !== {exp_o, exp_c, exp_z, exp_v, exp_n}) begin
            fails++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h x=%b: got o=%h czvn=%b want o=%h czvn=%b",
                     i, op, bus.a, bus.b, bus.x, got[BITS+3:4], got[3:0],
                     exp_o, {exp_c, exp_z, exp_v, exp_n});
         end
`ifdef ALU_XFLAG_EN
         tests++;
         if (bus.xf !== exp_xf) begin
            fails++;
            $display("FAIL random_xf[%0d] op=%0d: got %b want %b", i, op, bus.xf, exp_xf);
         end
`endif
      end
   endtask

   task automatic test_reset_mid();
      logic [BITS+3:0] got;
      issue(3'd0, 16'hFFFF, 16'hFFFF, 1'b0);
      @(negedge clk);
      bus.en = 1'b1; bus.op = 3'd2; bus.a = 16'h1234; bus.b = 16'h0001; bus.x = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      got = {bus.o, bus.c, bus.z, bus.v, bus.n};
      tests++;
      if (got !== {16'h0000, 4'b0100}) begin
         fails++;
         $display("FAIL reset_mid: got o=%h czvn=%b want o=0000 czvn=0100",
                  got[BITS+3:4], got[3:0]);
      end
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      // first extended issue after reset sees z_prev=1
      issue(3'd1, 16'h0000, 16'h0000, 1'b0);
      got = {bus.o, bus.c, bus.z, bus.v, bus.n};
      tests++;
      if (got !== {16'h0000, 4'b0100}) begin
         fails++;
         $display("FAIL reset_zprev: got o=%h czvn=%b want o=0000 czvn=0100",
                  got[BITS+3:4], got[3:0]);
      end
   endtask

`ifdef ALU_XFLAG_EN
   task automatic test_xflag();
      logic [2:0]  t_op [5];
      logic [15:0] t_a  [5];
      logic [15:0] t_b  [5];
      logic        t_xf [5];
      t_op = '{3'd0, 3'd4, 3'd0, 3'd7, 3'd5};
      t_a  = '{16'hFFFF, 16'h0000, 16'h0001, 16'h0005, 16'h0000};
      t_b  = '{16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000};
      t_xf = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      for (int i = 0; i < 5; i++) begin
         issue(t_op[i], t_a[i], t_b[i], 1'b0);
         tests++;
         if (bus.xf !== t_xf[i]) begin
            fails++;
            $display("FAIL xflag[%0d] op=%0d: got %b want %b", i, t_op[i], bus.xf, t_xf[i]);
         end
      end
   endtask
`endif

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      test_reset();
      test_directed();
      test_extended();
      test_hold();
`ifdef ALU_XFLAG_EN
      test_xflag();
`endif
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
